gn_mdl_axis_slv: RTL and testbench
==================================

// Module: gn_mdl_axis_slv
// PURPOSE
//  AXI4-Stream receiver (slave) model. It is the sink for the gn_mdl_axis_mst transmit path.
//  - Accepts beats under a programmable tready back-pressure profile.
//  - Buffers accepted beats in a first-word-fall-through FIFO, drained through a simple read port.
//  - Checks incoming data against an incrementing reference sequence.
//  - Flags AXI-Stream handshake protocol violations from the master.
// PARAMETERS
//  P_DWIDTH  32  tdata / FIFO data width in bits
//  P_DEPTH   16  FIFO depth in beats; must be a power of 2, minimum 2
//  P_AW      $clog2(P_DEPTH)  derived; not to be overridden
// PORTS
//  clk            in   1         clock; all logic on rising edge
//  reset          in   1         synchronous reset, active-high
//  rx_axis_tdata  in   P_DWIDTH  stream data
//  rx_axis_tvalid in   1         stream valid
//  rx_axis_tready out  1         stream ready
//  cfg_bp_mode    in   2         0=always, 1=pattern, 2=LFSR random, 3=never ready
//  cfg_bp_pattern in   8         ready pattern for mode 1; bit i used in cycle (i mod 8)
//  cfg_chk_en     in   1         1=data checker active
//  cfg_chk_seed   in   P_DWIDTH  first expected tdata value
//  rd_en          in   1         pop FIFO head; ignored when rd_valid=0
//  rd_data        out  P_DWIDTH  FIFO head (FWFT); 0 when empty
//  rd_valid       out  1         FIFO not empty
//  fifo_level     out  P_AW+1    beats currently stored, 0..P_DEPTH
//  beat_cnt       out  32        accepted beats; wraps modulo 2^32
//  err_cnt        out  16        checker mismatches; saturates at 16'hFFFF
//  proto_err      out  1         sticky protocol-violation flag
// BEHAVIOUR
//  Reset (reset=1 at clk edge)
//   - All outputs go to 0: tready, rd_valid, rd_data, fifo_level, beat_cnt, err_cnt, proto_err.
//   - bp_q <= 0, pattern index <= 0, LFSR <= 16'hACE1, FIFO pointers <= 0, exp <= cfg_chk_seed.
//   - Reset mid-transfer discards all buffered beats; no beat is accepted in a reset cycle.
//  Back-pressure
//   - bp_q is a register updated every cycle from the selected source:
//     mode0=1; mode1=cfg_bp_pattern[idx]; mode2=lfsr[0]; mode3=0.
//   - idx is a 3-bit free-running counter (+1/cycle, wraps 7->0).
//   - LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11; it shifts every cycle in all modes.
//   - rx_axis_tready = bp_q & ~full. There is no combinational path from tvalid to tready.
//   - Mode changes take effect on tready one cycle later.
//  Accept
//   - A beat is accepted when tvalid & tready at a clk edge.
//   - The beat is written to the FIFO and beat_cnt increments in the same edge.
//  FIFO
//   - FWFT, P_DEPTH entries, pointers P_AW+1 bits with wrap bit.
//   - full = (level == P_DEPTH).
//   - Latency accept -> rd_valid: 1 cycle.
//   - Pop when rd_en & rd_valid: rd_data presents the next entry after the edge.
//   - Write and pop in the same cycle: level unchanged.
//   - At full, tready=0 so no write occurs; a pop frees a slot and tready may rise in the next cycle.
//   - At empty, rd_en is ignored; level never underflows.
//  Checker
//   - While cfg_chk_en=0: exp <= cfg_chk_seed every cycle.
//   - While cfg_chk_en=1, on each accepted beat:
//     - If tdata != exp, err_cnt increments (saturating).
//     - exp <= exp+1, wrapping modulo 2^P_DWIDTH.
//  Protocol monitor
//   - Registers a "stalled" flag = tvalid & ~tready, together with tdata.
//   - If the previous cycle was stalled and the current cycle has tvalid=0 or a changed tdata,
//     proto_err <= 1 and stays set until reset.
//   - Detection is independent of cfg_bp_mode.
// TESTING
//  - Mode0, cfg_chk_en=1, seed=32'h100, master sends 100 beats 0x100..0x163, rd_en=1 constantly
//    -> beat_cnt=100, err_cnt=0, tready never drops after the first cycle following reset.
//  - Mode0, rd_en=0, send 20 beats -> fifo_level=16, tready=0 once full, 4 beats stalled.
//    Then pulse rd_en for 1 cycle -> tready=1 in the next cycle, one beat accepted.
//  - Mode1, pattern=8'b0101_0101, continuous tvalid -> exactly 4 accepts per 8 cycles, alternating.
//    Mode3 -> tready=0 for 50 cycles, beat_cnt unchanged.
//  - cfg_chk_en=1, seed=0, send 0,1,2,7,4 -> err_cnt=1 (only beat 7).
//    Then seed=32'hFFFF_FFFF, send FFFF_FFFF,0 -> no new errors (wrap).
//  - Master drops tvalid, or changes tdata, while tready=0 -> proto_err=1 one cycle later,
//    held until reset. A legal stall-hold -> proto_err stays 0.
//  - Reset asserted with fifo_level=9 in mode2 -> next cycle fifo_level=0, rd_valid=0,
//    err_cnt=0, tready=0. After release, LFSR sequence repeats from 16'hACE1.

Source files
------------

// File: rtl/gn_mdl_axis_slv.sv
// AXI4-Stream sink model: programmable tready back-pressure, FWFT receive FIFO,
// incrementing-sequence data checker and handshake protocol monitor.
module gn_mdl_axis_slv #(
  parameter int P_DWIDTH = 32,
  parameter int P_DEPTH  = 16,
  parameter int P_AW     = $clog2(P_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [P_DWIDTH-1:0] rx_axis_tdata,
  input  logic                rx_axis_tvalid,
  output logic                rx_axis_tready,
  input  logic [1:0]          cfg_bp_mode,
  input  logic [7:0]          cfg_bp_pattern,
  input  logic                cfg_chk_en,
  input  logic [P_DWIDTH-1:0] cfg_chk_seed,
  input  logic                rd_en,
  output logic [P_DWIDTH-1:0] rd_data,
  output logic                rd_valid,
  output logic [P_AW:0]       fifo_level,
  output logic [31:0]         beat_cnt,
  output logic [15:0]         err_cnt,
  output logic                proto_err
);

  localparam logic [P_AW:0]       DEPTH_L  = (P_AW+1)'(P_DEPTH);
  localparam logic [P_AW:0]       PTR_ONE  = (P_AW+1)'(1);
  localparam logic [P_DWIDTH-1:0] EXP_ONE  = P_DWIDTH'(1);
  localparam logic [15:0]         LFSR_INI = 16'hACE1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  logic [P_DWIDTH-1:0] mem [P_DEPTH];
  logic [P_AW:0]       wr_ptr, rd_ptr;
  logic [P_AW:0]       level;
  logic                full;
  logic                wr_en, pop;
  logic                bp_q, bp_next;
  logic [2:0]          idx;
  logic [15:0]         lfsr;
  logic [P_DWIDTH-1:0] exp_q;
  logic                stall_p1;
  logic [P_DWIDTH-1:0] tdata_p1;

  assign level          = wr_ptr - rd_ptr;
  assign full           = (level == DEPTH_L);
  assign rd_valid       = (level != '0);
  assign fifo_level     = level;
  assign rx_axis_tready = bp_q & ~full;
  // A beat presented during a reset cycle is never taken, even if tready was high.
  assign wr_en          = rx_axis_tvalid & rx_axis_tready & ~reset;
  assign pop            = rd_en & rd_valid;
  assign rd_data        = rd_valid ? mem[rd_ptr[P_AW-1:0]] : '0;

  always_comb begin
    bp_next = 1'b0;
    case (cfg_bp_mode)
      2'd0:    bp_next = 1'b1;
      2'd1:    bp_next = cfg_bp_pattern[idx];
      2'd2:    bp_next = lfsr[0];
      default: bp_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_q      <= 1'b0;
      idx       <= 3'd0;
      lfsr      <= LFSR_INI;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat_cnt  <= 32'd0;
      err_cnt   <= 16'd0;
      exp_q     <= cfg_chk_seed;
      stall_p1  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      bp_q <= bp_next;
      idx  <= idx + 3'd1;
      lfsr <= lfsr_next(lfsr);
      if (wr_en) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (!cfg_chk_en)
        exp_q <= cfg_chk_seed;
      else if (wr_en) begin
        if (rx_axis_tdata != exp_q)
          err_cnt <= sat_inc16(err_cnt);
        exp_q <= exp_q + EXP_ONE;
      end
      // p1 stage: last cycle's stall vs. this cycle's tvalid/tdata
      stall_p1 <= rx_axis_tvalid & ~rx_axis_tready;
      if (stall_p1 && (!rx_axis_tvalid || rx_axis_tdata != tdata_p1))
        proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    tdata_p1 <= rx_axis_tdata;
    if (wr_en)
      mem[wr_ptr[P_AW-1:0]] <= rx_axis_tdata;
  end

endmodule

// File: tb/tb_gn_mdl_axis_slv.sv
// Directed bench for gn_mdl_axis_slv: reset, back-pressure modes, FIFO fill/drain,
// checker, protocol monitor and reset-during-traffic.
module tb_gn_mdl_axis_slv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_axis_tdata;
  logic        rx_axis_tvalid;
  logic        rx_axis_tready;
  logic [1:0]  cfg_bp_mode;
  logic [7:0]  cfg_bp_pattern;
  logic        cfg_chk_en;
  logic [31:0] cfg_chk_seed;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_level;
  logic [31:0] beat_cnt;
  logic [15:0] err_cnt;
  logic        proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  gn_mdl_axis_slv dut (
    .clk(clk), .reset(reset),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready),
    .cfg_bp_mode(cfg_bp_mode), .cfg_bp_pattern(cfg_bp_pattern),
    .cfg_chk_en(cfg_chk_en), .cfg_chk_seed(cfg_chk_seed),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
    .beat_cnt(beat_cnt), .err_cnt(err_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Legal master: hold the beat until the handshake completes.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = d;
    while (rx_axis_tready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) chk("send_timeout", 32'(n), 32'd0);
    step();
    rx_axis_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        prev_rdy;
    logic [15:0] l;

    reset = 1'b1; rx_axis_tdata = '0; rx_axis_tvalid = 1'b0;
    cfg_bp_mode = 2'd0; cfg_bp_pattern = 8'h00; cfg_chk_en = 1'b1;
    cfg_chk_seed = 32'h100; rd_en = 1'b1;
    step(); step();
    chk("rst_tready", rx_axis_tready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_proto", proto_err, 0);
    reset = 1'b0;
    step();

    // Mode0 streaming with continuous drain: 100 in-sequence beats
    for (int i = 0; i < 100; i++) begin
      rx_axis_tvalid = 1'b1;
      rx_axis_tdata  = 32'h100 + 32'(i);
      chk("t1_tready", rx_axis_tready, 1);
      if (i > 0) chk("t1_head", rd_data, 32'h100 + 32'(i) - 1);
      step();
    end
    rx_axis_tvalid = 1'b0;
    chk("t1_beat", beat_cnt, 100);
    chk("t1_err", err_cnt, 0);
    chk("t1_last_head", rd_data, 32'h163);
    step();
    chk("t1_drained", fifo_level, 0);

    // Fill to full with no draining, then stall, then single pop
    cfg_chk_en = 1'b0; rd_en = 1'b0;
    for (int k = 0; k < 16; k++) send(32'(k));
    chk("t2_full_level", fifo_level, 16);
    chk("t2_full_tready", rx_axis_tready, 0);
    chk("t2_beat16", beat_cnt, 116);
    rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'd16;
    for (int k = 0; k < 4; k++) begin
      chk("t2_stall_tready", rx_axis_tready, 0);
      step();
    end
    chk("t2_stall_beat", beat_cnt, 116);
    chk("t2_stall_level", fifo_level, 16);
    chk("t2_stall_proto", proto_err, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t2_pop_tready", rx_axis_tready, 1);
    chk("t2_pop_level", fifo_level, 15);
    step();
    rx_axis_tvalid = 1'b0;
    chk("t2_refill_beat", beat_cnt, 117);
    chk("t2_refill_level", fifo_level, 16);
    chk("t2_refill_tready", rx_axis_tready, 0);
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t2_drain_data", rd_data, 32'(k + 1));
      step();
    end
    rd_en = 1'b0;
    chk("t2_empty_level", fifo_level, 0);
    chk("t2_empty_valid", rd_valid, 0);
    chk("t2_empty_data", rd_data, 0);
    rd_en = 1'b1;
    step();
    chk("t2_empty_pop_level", fifo_level, 0);

    // Mode1 alternating pattern: 4 accepts in 8 cycles
    cfg_bp_mode = 2'd1; cfg_bp_pattern = 8'b0101_0101;
    step();
    rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'hAA;
    prev_rdy = rx_axis_tready;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) chk("t3_alternate", rx_axis_tready, !prev_rdy);
      prev_rdy = rx_axis_tready;
      step();
    end
    chk("t3_beat_8cyc", beat_cnt, 121);
    if (rx_axis_tready !== 1'b1) step();
    step();
    rx_axis_tvalid = 1'b0;
    chk("t3_beat_end", beat_cnt, 122);

    // Mode3: never ready
    cfg_bp_mode = 2'd3;
    step();
    rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'hBB;
    for (int c = 0; c < 50; c++) begin
      chk("t3_m3_tready", rx_axis_tready, 0);
      step();
    end
    chk("t3_m3_beat", beat_cnt, 122);
    cfg_bp_mode = 2'd0;
    step();
    chk("t3_m0_back", rx_axis_tready, 1);
    step();
    rx_axis_tvalid = 1'b0;
    chk("t3_m0_beat", beat_cnt, 123);
    chk("t3_proto_legal", proto_err, 0);

    // Checker: one bad beat, then wrap of the expected sequence
    cfg_chk_en = 1'b0; cfg_chk_seed = 32'd0;
    step();
    cfg_chk_en = 1'b1;
    send(32'd0); send(32'd1); send(32'd2); send(32'd7); send(32'd4);
    chk("t4_err_one", err_cnt, 1);
    cfg_chk_en = 1'b0; cfg_chk_seed = 32'hFFFF_FFFF;
    step();
    cfg_chk_en = 1'b1;
    send(32'hFFFF_FFFF); send(32'd0); send(32'd1);
    chk("t4_err_wrap", err_cnt, 1);
    chk("t4_beat", beat_cnt, 131);
    cfg_chk_en = 1'b0;

    // Protocol monitor: tdata change while stalled, then tvalid drop while stalled
    chk("t5_proto_pre", proto_err, 0);
    cfg_bp_mode = 2'd3;
    step(); step();
    rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'd5;
    step(); step();
    chk("t5_hold_ok", proto_err, 0);
    rx_axis_tdata = 32'd6;
    step();
    chk("t5_data_change", proto_err, 1);
    rx_axis_tvalid = 1'b0; cfg_bp_mode = 2'd0;
    step(); step();
    chk("t5_sticky", proto_err, 1);
    cfg_bp_mode = 2'd3; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_clear", proto_err, 0);
    step();
    rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'd9;
    step(); step();
    chk("t5_hold_ok2", proto_err, 0);
    rx_axis_tvalid = 1'b0;
    step();
    chk("t5_valid_drop", proto_err, 1);

    // Reset with traffic buffered in mode2, then LFSR replay
    reset = 1'b1; cfg_bp_mode = 2'd2; rd_en = 1'b0; cfg_chk_en = 1'b1; cfg_chk_seed = 32'd0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) send(32'h100 + 32'(k));
    chk("t6_level9", fifo_level, 9);
    chk("t6_err9", err_cnt, 9);
    chk("t6_beat9", beat_cnt, 9);
    reset = 1'b1; rx_axis_tvalid = 1'b1; rx_axis_tdata = 32'h55;
    step();
    rx_axis_tvalid = 1'b0;
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_data", rd_data, 0);
    chk("t6_rst_err", err_cnt, 0);
    chk("t6_rst_tready", rx_axis_tready, 0);
    chk("t6_rst_beat", beat_cnt, 0);
    chk("t6_rst_proto", proto_err, 0);
    step();
    reset = 1'b0;
    l = 16'hACE1;
    for (int c = 0; c < 16; c++) begin
      step();
      chk("t6_lfsr_tready", rx_axis_tready, l[0]);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    chk("t6_lfsr_beat", beat_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
